// File: rtl/sipo_deserializer.sv
// Serial-to-parallel collector: assembles WIDTH-bit words from a gappy valid/bit
// stream and presents them on a single-entry ready/valid output register.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int GAP_MAX   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_i,
    input  logic             valid_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             frame_err_o,
    output logic             overflow_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]    GAP_LIM  = 8'(GAP_MAX);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, COLLECT} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
    logic [WIDTH-1:0] par_q, par_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;
    logic             ovf_q, ovf_d;
    logic             done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            sr_q    <= '0;
            par_q   <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        if (MSB_FIRST != 0) sr_shift = {sr_q[WIDTH-2:0], serial_i};
        else                sr_shift = {serial_i, sr_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        sr_d    = sr_q;
        par_d   = par_q;
        vld_d   = vld_q & ~ready_i;
        ovf_d   = ovf_q;
        ferr_d  = 1'b0;
        done    = 1'b0;

        if (valid_i) begin
            sr_d  = sr_shift;
            gap_d = '0;
            if (cnt_q == LAST_BIT) begin
                cnt_d   = '0;
                state_d = IDLE;
                done    = 1'b1;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                state_d = COLLECT;
            end
        end else if (state_q == COLLECT) begin
            // Abort on the idle edge that would bring the counter to GAP_MAX.
            if (GAP_MAX != 0 && gap_q == GAP_LIM - 8'd1) begin
                cnt_d   = '0;
                state_d = IDLE;
                gap_d   = '0;
                sr_d    = '0;
                ferr_d  = 1'b1;
            end else begin
                gap_d = gap_q + 8'd1;
            end
        end else begin
            gap_d = '0;
        end

        // A full register may still take the new word if it drains this edge.
        if (done) begin
            if (!vld_q || ready_i) begin
                par_d = sr_shift;
                vld_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign parallel_o  = par_q;
    assign valid_o     = vld_q;
    assign busy_o      = (state_q == COLLECT);
    assign frame_err_o = ferr_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: a bit-list/word-level model is checked
// against the DUT every cycle, with literal expectations pinning the model.
module tb_sipo_deserializer;

    localparam int W   = 4;
    localparam int GAP = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ser = 1'b0, vin = 1'b0, rdy = 1'b0;
    logic [W-1:0] par;
    logic         vout, busy, ferr, ovf;

    int npass = 0;
    int ntotal = 0;

    // Behavioural model state
    int           bits[$];
    int           m_gap = 0;
    logic [W-1:0] m_par = '0;
    logic         m_valid = 1'b0, m_ovf = 1'b0, m_ferr = 1'b0;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1), .GAP_MAX(GAP)) dut (
        .clk(clk), .reset(rst_n), .serial_i(ser), .valid_i(vin), .ready_i(rdy),
        .parallel_o(par), .valid_o(vout), .busy_o(busy),
        .frame_err_o(ferr), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        bits.delete();
        m_gap = 0; m_par = '0; m_valid = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic v, input logic r);
        logic         complete;
        logic [W-1:0] word;
        complete = 1'b0;
        word = '0;
        m_ferr = 1'b0;
        if (v) begin
            bits.push_back(int'(s));
            m_gap = 0;
            if (bits.size() == W) begin
                // first received bit ends up most significant
                foreach (bits[i]) word = W'((int'(word) * 2 + bits[i]) % (1 << W));
                complete = 1'b1;
                bits.delete();
            end
        end else if (bits.size() > 0) begin
            m_gap++;
            if (m_gap == GAP) begin
                bits.delete();
                m_gap = 0;
                m_ferr = 1'b1;
            end
        end else begin
            m_gap = 0;
        end
        if (complete) begin
            if (!m_valid || r) begin
                m_par = word;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare();
        chk("valid_o", 32'(vout), 32'(m_valid));
        chk("busy_o", 32'(busy), 32'(bits.size() != 0));
        chk("frame_err_o", 32'(ferr), 32'(m_ferr));
        chk("overflow_o", 32'(ovf), 32'(m_ovf));
        if (m_valid) chk("parallel_o", 32'(par), 32'(m_par));
    endtask

    task automatic step(input logic s, input logic v, input logic r);
        ser = s; vin = v; rdy = r;
        @(posedge clk);
        model_edge(s, v, r);
        @(negedge clk);
        compare();
    endtask

    task automatic send_word(input logic [W-1:0] w, input int idle, input logic r);
        for (int i = W - 1; i >= 0; i--) begin
            step(w[i], 1'b1, r);
            if (i != 0) for (int k = 0; k < idle; k++) step(1'b0, 1'b0, r);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst parallel_o", 32'(par), 32'h0);
        chk("rst outputs", {28'h0, vout, busy, ferr, ovf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        ser = 1'b0; vin = 1'b0; rdy = 1'b0;
        #12;
        do_reset();
        step(1'b0, 1'b0, 1'b0);

        // Basic word 1,0,1,1 -> B
        step(1'b1, 1'b1, 1'b1);
        chk("basic busy after bit1", 32'(busy), 32'h1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("basic model word", 32'(m_par), 32'hB);
        chk("basic parallel_o", 32'(par), 32'hB);
        chk("basic valid_o", 32'(vout), 32'h1);
        chk("basic busy after bit4", 32'(busy), 32'h0);
        step(1'b0, 1'b0, 1'b1);
        chk("basic valid drained", 32'(vout), 32'h0);

        // Upstream cadence with idle gaps shorter than the timeout
        send_word(4'h5, 3, 1'b1);
        chk("cadence word 5", 32'(par), 32'h5);
        step(1'b0, 1'b0, 1'b1);
        send_word(4'hC, 1, 1'b1);
        chk("cadence word C", 32'(par), 32'hC);
        chk("cadence no frame err", 32'(ferr), 32'h0);
        step(1'b0, 1'b0, 1'b1);

        // Back-pressure: second word dropped
        send_word(4'hB, 0, 1'b0);
        send_word(4'h5, 0, 1'b0);
        chk("bp holds B", 32'(par), 32'hB);
        chk("bp overflow set", 32'(ovf), 32'h1);
        step(1'b0, 1'b0, 1'b1);
        chk("bp valid dropped", 32'(vout), 32'h0);
        chk("bp overflow sticky", 32'(ovf), 32'h1);

        // Simultaneous drain and load
        @(negedge clk);
        do_reset();
        send_word(4'h3, 0, 1'b0);
        chk("dl holds 3", 32'(par), 32'h3);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("dl parallel 9", 32'(par), 32'h9);
        chk("dl valid stays", 32'(vout), 32'h1);
        chk("dl no overflow", 32'(ovf), 32'h0);
        step(1'b0, 1'b0, 1'b1);

        // Gap timeout after two bits, then a clean word
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < GAP - 1; k++) step(1'b0, 1'b0, 1'b1);
        chk("gap still busy at 7", 32'(busy), 32'h1);
        step(1'b0, 1'b0, 1'b1);
        chk("gap frame_err pulse", 32'(ferr), 32'h1);
        chk("gap busy cleared", 32'(busy), 32'h0);
        step(1'b0, 1'b0, 1'b1);
        chk("gap frame_err one cycle", 32'(ferr), 32'h0);
        send_word(4'h6, 0, 1'b1);
        chk("gap then word 6", 32'(par), 32'h6);
        step(1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-word
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        #2;
        do_reset();
        send_word(4'hF, 0, 1'b1);
        chk("post-reset word F", 32'(par), 32'hF);
        step(1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-to-parallel collector that sits directly downstream of the 4-bit PISO serializer. It consumes the serializer's `serial_o`/`valid_o` bit stream, which includes arbitrary idle gaps between bits, and reassembles WIDTH-bit words. Each completed word is presented on a single-entry ready/valid output register. A gap timeout discards stalled partial words, and a sticky flag reports words dropped under back-pressure.

## Interface

- `WIDTH`, 4: bits per word; must be ≥2.
- `MSB_FIRST`, 1: 1 means the first received bit lands in bit WIDTH-1; 0 means it lands in bit 0.
- `GAP_MAX`, 8: consecutive idle cycles mid-word that abort the partial word; 0 disables the timeout; must be < 256.

- `clk`  input  1  clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `serial_i`  input  1  serial data bit; connects to serializer `serial_o`.
- `valid_i`  input  1  `serial_i` is a valid bit this cycle; connects to serializer `valid_o`.
- `ready_i`  input  1  consumer accepts `parallel_o` this cycle.
- `parallel_o`  output  WIDTH  assembled word.
- `valid_o`  output  1  `parallel_o` holds an unconsumed word.
- `busy_o`  output  1  a partial word is in progress (bit count ≠ 0).
- `frame_err_o`  output  1  one-cycle pulse: partial word discarded by gap timeout.
- `overflow_o`  output  1  sticky: a completed word was dropped because the output register was full.

## Operation

- **States:** IDLE (bit count 0) and COLLECT (bit count 1..WIDTH-1). `busy_o` = (state == COLLECT).
- **Bit capture:** every edge with `valid_i`=1 shifts `serial_i` into the shift register and increments the bit count. Shift direction follows `MSB_FIRST`.
  - IDLE → COLLECT on the first bit.
  - The WIDTH-th bit completes the word. Bit count returns to 0 and state returns to IDLE on the same edge.
- **Word completion:**
  - If `valid_o`=0, or `valid_o`&`ready_i`=1 on that same edge, the completed word loads `parallel_o` and `valid_o` becomes or stays 1.
  - Otherwise the completed word is dropped, `overflow_o` is set to 1, and `parallel_o` is unchanged.
- **Output handshake:** a transfer occurs on an edge where `valid_o`&`ready_i`=1. After a transfer with no simultaneous load, `valid_o` goes to 0. `parallel_o` keeps its last value; it is don't-care while `valid_o`=0 but is not cleared.
- **Gap timeout (GAP_MAX>0):**
  - An 8-bit gap counter clears on any `valid_i`=1 edge and in IDLE.
  - In COLLECT, the counter increments on each `valid_i`=0 edge.
  - On the edge where it would reach GAP_MAX: the partial word is discarded, bit count → 0, state → IDLE, and `frame_err_o`=1 for exactly the following cycle.
  - The output register is unaffected by a timeout.
- **Back-pressure does not stall capture.** Collection continues regardless of `ready_i`. There is no ready signal upstream, because the serializer has no back-pressure input.
- **`overflow_o`** clears only on reset.
- **Reset (asynchronous, active-low), including mid-word:** immediately forces
  - bit count 0, state IDLE, gap counter 0, shift register 0;
  - `parallel_o`=0, `valid_o`=0, `busy_o`=0, `frame_err_o`=0, `overflow_o`=0.
  - The partial word is lost. The first `valid_i` bit after deassertion starts a new word.

## Timing

- **Latency:** the final bit is sampled on edge N; `parallel_o`/`valid_o` are valid from edge N through the cycle after it. Minimum word period is WIDTH cycles with back-to-back bits.
- **Throughput:** one word per WIDTH valid bits with `ready_i` held at 1; no bubble is required between words.
- **Outputs:** all outputs are registered; there are no combinational paths from any input to any output.
- **Simultaneous completion and timeout:** cannot occur, because completion requires `valid_i`=1, which clears the gap counter.
- **Simultaneous completion and drain:** completion on the same edge as a drain loads the new word. `valid_o` stays 1 and `overflow_o` is not set.

## Test plan

- **Basic word (WIDTH=4, MSB_FIRST=1):** after reset, bits 1,0,1,1 on four consecutive `valid_i` cycles with `ready_i`=1 → `parallel_o`=4'hB and `valid_o`=1 for one cycle after the 4th edge; `busy_o` high during bits 2–4 only.
- **Upstream cadence:** bits for 4'h5 spaced with 3 idle cycles each (< GAP_MAX), then 4'hC spaced by 1 idle cycle → two words, 4'h5 then 4'hC, with `frame_err_o` never asserted.
- **Back-pressure:** `ready_i`=0, send 4'hB then 4'h5 → `parallel_o` holds 4'hB and `overflow_o`=1 after the 4'h5 final bit. Raise `ready_i` → `valid_o` drops; `overflow_o` stays 1.
- **Simultaneous drain and load:** `valid_o`=1 holding 4'h3; `ready_i`=1 on the edge the final bit of 4'h9 arrives → `parallel_o`=4'h9, `valid_o` stays 1, `overflow_o`=0.
- **Gap timeout:** bits 1,1, then 8 idle cycles → `frame_err_o` pulses once and `busy_o`=0. Then bits 0,1,1,0 → `parallel_o`=4'h6.
- **Reset mid-word:** bits 1,0 received, assert `reset` low asynchronously between edges → all outputs 0 immediately. After release, bits 1,1,1,1 → `parallel_o`=4'hF.
